aes_out_unpacker: RTL and testbench

- Output stage directly downstream of the AES-128 encryption core.
- Captures each 128-bit ciphertext block on the cycle the core asserts valid and buffers it in a DEPTH-entry block FIFO.
- Serialises each buffered block onto a 32-bit valid/ready stream, most-significant word first, so a narrow consumer can apply backpressure without stalling the core's fixed-timing output.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_block_fifo.sv | 67 ++++++
 rtl/aes_out_unpacker.sv | 83 ++++++++
 tb/tb_aes_out_unpacker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and widths for the AES output path.
package aes_pkg;

   localparam int unsigned WORD_W          = 32;
   localparam int unsigned BLOCK_W         = 128;
   localparam int unsigned WORDS_PER_BLOCK = 4;

   typedef logic [WORD_W-1:0]  word_t;
   typedef logic [BLOCK_W-1:0] block_t;
   typedef logic [1:0]         widx_t;

   // Word 0 is the most-significant 32 bits of the block.
   function automatic word_t word_sel(input block_t blk, input widx_t idx);
      word_t w;
      case (idx)
         2'd0:    w = blk[127:96];
         2'd1:    w = blk[95:64];
         2'd2:    w = blk[63:32];
         default: w = blk[31:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// DEPTH x 128-bit synchronous block FIFO; a push while full is accepted
// when a pop happens at the same edge.
module aes_block_fifo
   import aes_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  block_t                       i_data,
   input  logic                         i_pop,
   output logic                         o_accept,
   output block_t                       o_head,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   block_t             r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wp;
   logic [PTR_W-1:0]   r_rp;
   logic [CNT_W-1:0]   r_count;

   logic               w_pop;
   logic               w_accept;

   assign o_full   = (r_count == CNT_W'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign w_pop    = i_pop & ~o_empty;
   assign w_accept = i_push & (~o_full | w_pop);
   assign o_accept = w_accept;
   assign o_head   = r_mem[r_rp];
   assign o_count  = r_count;

   // Storage write; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_wp] <= i_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_accept) begin
            r_wp <= r_wp + PTR_W'(1);
         end
         if (w_pop) begin
            r_rp <= r_rp + PTR_W'(1);
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/aes_out_unpacker.sv
// Buffers AES-128 ciphertext blocks and streams them as 32-bit words,
// most-significant word first, on a valid/ready interface.
// Optional: define AES_OUT_LAST_EN to add the m_last end-of-block marker.
module aes_out_unpacker
   import aes_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [BLOCK_W-1:0]           blk_in,
   input  logic                         blk_valid,
   output logic [WORD_W-1:0]            m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         overflow,
   output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef AES_OUT_LAST_EN
   ,
   output logic                         m_last
`endif
);

   widx_t   r_widx;
   logic    r_overflow;

   block_t  w_head;
   logic    w_full;
   logic    w_empty;
   logic    w_accept;
   logic    w_xfer;
   logic    w_pop_blk;
   logic    w_drop;

   aes_block_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_push   (blk_valid),
      .i_data   (blk_in),
      .i_pop    (w_pop_blk),
      .o_accept (w_accept),
      .o_head   (w_head),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_count  (level)
   );

   assign m_valid   = ~w_empty;
   assign w_xfer    = m_valid & m_ready;
   assign w_pop_blk = w_xfer & (r_widx == 2'd3);
   assign w_drop    = blk_valid & w_full & ~w_pop_blk;
   assign m_data    = m_valid ? word_sel(w_head, r_widx) : '0;
   assign overflow  = r_overflow;

`ifdef AES_OUT_LAST_EN
   assign m_last    = m_valid & (r_widx == 2'd3);
`endif

   // Word index advances on every transfer and wraps at the end of a block.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_widx <= '0;
      end else if (w_xfer) begin
         r_widx <= r_widx + 2'd1;
      end
   end

   // Sticky drop indicator, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

   // w_accept is informational here; the FIFO applies it internally.
   logic w_unused;
   assign w_unused = w_accept;

endmodule

// File: tb/tb_aes_out_unpacker.sv
// Directed self-checking bench for aes_out_unpacker (DEPTH=2).
`timescale 1ns/1ps
module tb_aes_out_unpacker;
   import aes_pkg::*;

   localparam int unsigned DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [127:0]  blk_in;
   logic          blk_valid;
   logic [31:0]   m_data;
   logic          m_valid;
   logic          m_ready;
   logic          overflow;
   logic [1:0]    level;
`ifdef AES_OUT_LAST_EN
   logic          m_last;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [127:0] BLK_A = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] BLK_C = 128'hdeadbeefcafef00d0123456789abcdef;
   localparam logic [127:0] BLK_D = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;
   localparam logic [127:0] BLK_E = 128'h1111111122222222333333334444444;

   logic [31:0] wa [4] = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};
   logic [31:0] wb [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
   logic [31:0] wd [4] = '{32'ha5a5a5a5, 32'h5a5a5a5a, 32'h0f0f0f0f, 32'hf0f0f0f0};
   logic [31:0] we [4] = '{32'h01111111, 32'h12222222, 32'h23333333, 32'h34444444};

   always #5 clk = ~clk;

   aes_out_unpacker #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .blk_in    (blk_in),
      .blk_valid (blk_valid),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .overflow  (overflow),
      .level     (level)
`ifdef AES_OUT_LAST_EN
      ,
      .m_last    (m_last)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; blk_valid = 1'b0; m_ready = 1'b0; blk_in = '0;
      step(); step();
      rst = 1'b0;
      n_checks++;
      if (m_valid !== 1'b0 || m_data !== 32'h0 || level !== 2'd0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: m_valid=%b m_data=%h level=%0d overflow=%b (want 0,0,0,0)",
                  m_valid, m_data, level, overflow);
      end
   endtask

   task automatic test_fips();
      blk_in = BLK_A; blk_valid = 1'b1; m_ready = 1'b1;
      step();
      blk_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== wa[i]) begin
            n_fail++;
            $display("FAIL fips_word%0d: m_valid=%b m_data=%h want 1 %h", i, m_valid, m_data, wa[i]);
         end
`ifdef AES_OUT_LAST_EN
         n_checks++;
         if (m_last !== (i == 3)) begin
            n_fail++;
            $display("FAIL fips_last%0d: m_last=%b want %b", i, m_last, (i == 3));
         end
`endif
         step();
      end
      n_checks++;
      if (m_valid !== 1'b0 || level !== 2'd0 || m_data !== 32'h0) begin
         n_fail++;
         $display("FAIL fips_drain: m_valid=%b level=%0d m_data=%h want 0 0 0", m_valid, level, m_data);
      end
   endtask

   task automatic test_backpressure();
      logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int k = 0;
      blk_in = BLK_A; blk_valid = 1'b1; m_ready = 1'b0;
      step();
      blk_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== wa[k]) begin
            n_fail++;
            $display("FAIL bp_cycle%0d: m_valid=%b m_data=%h want 1 %h", i, m_valid, m_data, wa[k]);
         end
         m_ready = pat[i];
         step();
         if (pat[i]) k++;
      end
      m_ready = 1'b0;
      n_checks++;
      if (m_valid !== 1'b0 || level !== 2'd0) begin
         n_fail++;
         $display("FAIL bp_end: m_valid=%b level=%0d want 0 0", m_valid, level);
      end
   endtask

   task automatic test_overflow();
      m_ready = 1'b0;
      blk_in = BLK_A; blk_valid = 1'b1; step();
      blk_in = BLK_B; step();
      n_checks++;
      if (level !== 2'd2 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_full: level=%0d overflow=%b want 2 0", level, overflow);
      end
      blk_in = BLK_C; step();
      blk_valid = 1'b0;
      n_checks++;
      if (level !== 2'd2 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_drop: level=%0d overflow=%b want 2 1", level, overflow);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [31:0] exp_w;
         exp_w = (i < 4) ? wa[i] : wb[i-4];
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== exp_w) begin
            n_fail++;
            $display("FAIL ovf_word%0d: m_valid=%b m_data=%h want 1 %h", i, m_valid, m_data, exp_w);
         end
         step();
      end
      n_checks++;
      if (m_valid !== 1'b0 || overflow !== 1'b1 || level !== 2'd0) begin
         n_fail++;
         $display("FAIL ovf_end: m_valid=%b overflow=%b level=%0d want 0 1 0", m_valid, overflow, level);
      end
      m_ready = 1'b0;
   endtask

   task automatic test_full_pop();
      m_ready = 1'b0;
      blk_in = BLK_A; blk_valid = 1'b1; step();
      blk_in = BLK_B; step();
      blk_valid = 1'b0;
      m_ready = 1'b1;
      step(); step(); step();
      n_checks++;
      if (m_data !== wa[3] || level !== 2'd2) begin
         n_fail++;
         $display("FAIL fp_pre: m_data=%h level=%0d want %h 2", m_data, level, wa[3]);
      end
      blk_in = BLK_D; blk_valid = 1'b1;
      step();
      blk_valid = 1'b0;
      n_checks++;
      if (level !== 2'd2 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL fp_accept: level=%0d overflow=%b want 2 0", level, overflow);
      end
      for (int i = 0; i < 8; i++) begin
         logic [31:0] exp_w;
         exp_w = (i < 4) ? wb[i] : wd[i-4];
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== exp_w) begin
            n_fail++;
            $display("FAIL fp_word%0d: m_valid=%b m_data=%h want 1 %h", i, m_valid, m_data, exp_w);
         end
         step();
      end
      n_checks++;
      if (m_valid !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL fp_end: m_valid=%b overflow=%b want 0 0", m_valid, overflow);
      end
      m_ready = 1'b0;
   endtask

   task automatic test_reset_mid_block();
      m_ready = 1'b0;
      blk_in = BLK_A; blk_valid = 1'b1; step();
      blk_in = BLK_B; step();
      blk_in = BLK_C; step();
      blk_valid = 1'b0;
      m_ready = 1'b1;
      step(); step();
      n_checks++;
      if (m_data !== wa[2] || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL rm_pre: m_data=%h overflow=%b want %h 1", m_data, overflow, wa[2]);
      end
      rst = 1'b1; step();
      rst = 1'b0;
      n_checks++;
      if (m_valid !== 1'b0 || m_data !== 32'h0 || level !== 2'd0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_reset: m_valid=%b m_data=%h level=%0d overflow=%b want 0 0 0 0",
                  m_valid, m_data, level, overflow);
      end
      blk_in = BLK_E; blk_valid = 1'b1; step();
      blk_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== we[i]) begin
            n_fail++;
            $display("FAIL rm_word%0d: m_valid=%b m_data=%h want 1 %h", i, m_valid, m_data, we[i]);
         end
         step();
      end
      n_checks++;
      if (m_valid !== 1'b0 || level !== 2'd0) begin
         n_fail++;
         $display("FAIL rm_end: m_valid=%b level=%0d want 0 0", m_valid, level);
      end
      m_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fips();
      test_backpressure();
      test_reset();
      test_overflow();
      test_reset();
      test_full_pop();
      test_reset();
      test_reset_mid_block();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
